sha256_round_sequencer: RTL and testbench
=========================================

SHA256_ROUND_SEQUENCER -- requirements
Module: sha256_round_sequencer

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  a job is offered on rx_state/rx_block.
REQ-005 in_ready  output  1  the sequencer accepts a job this cycle.
REQ-006 rx_state  input  256  chaining state; word 0 (bits 31:0) = A ... word 7 = H.
REQ-007 rx_block  input  512  message block; word 0 (bits 31:0) = W[0] ... word 15 = W[15].
REQ-008 rnd_state_o  output  256  state fed to the external combinational round unit.
REQ-009 rnd_w_o  output  512  schedule window fed to the round unit; word 0 = W[t].
REQ-010 rnd_k_o  output  32  round constant K[t] for the current round.
REQ-011 rnd_state_i  input  256  next state returned by the round unit.
REQ-012 rnd_w_i  input  512  next window returned by the round unit: {W_new, window[511:32]}.
REQ-013 rnd_active  output  1  high while a round is being issued.
REQ-014 out_valid  output  1  tx_hash holds a result.
REQ-015 out_ready  input  1  the consumer accepts the result.
REQ-016 tx_hash  output  256  result, with the same word order as rx_state.

Function
REQ-017 FSM states SHALL be IDLE, RUN, FIN and OUT; in_ready=1 only in IDLE, rnd_active=1 only in RUN, out_valid=1 only in OUT.
REQ-018 IDLE with in_valid=1 at an edge: the block SHALL capture rx_state into st_reg and iv_reg, capture rx_block into w_reg, clear the 6-bit round counter, and go to RUN.
REQ-019 In RUN, rnd_state_o=st_reg, rnd_w_o=w_reg and rnd_k_o=K[cnt], where K is the 64-entry FIPS 180-4 constant table held in an internal ROM.
REQ-020 Each RUN edge SHALL load st_reg<=rnd_state_i, w_reg<=rnd_w_i and cnt<=cnt+1.
REQ-021 The RUN edge with cnt=63 SHALL go to FIN; cnt wraps to 0 there.
REQ-022 The FIN edge SHALL load tx_hash (see REQ-031/032) and go to OUT.
REQ-023 Latency: an accept at edge T SHALL give out_valid=1 after edge T+65 (64 RUN edges plus 1 FIN edge), independent of data.
REQ-024 OUT SHALL hold tx_hash stable until an edge with out_ready=1, then go to IDLE.
REQ-025 Acceptance of a new job SHALL NOT occur in the same cycle as an output handshake; the minimum job-to-job spacing is 67 cycles.
REQ-026 in_valid is ignored outside IDLE; rx_state and rx_block are sampled only on the accept edge.
REQ-027 All additions are modulo 2^32 per word; no carry crosses a word boundary.
REQ-028 Outside RUN, rnd_k_o SHALL be 0; rnd_state_o and rnd_w_o show the register contents and are don't-care to the round unit.

Reset
REQ-029 While rst=1, the block SHALL force: state=IDLE, cnt=0, st_reg=0, iv_reg=0, w_reg=0, tx_hash=0, out_valid=0, rnd_active=0, rnd_k_o=0, in_ready=0.
REQ-030 After rst deasserts, in_ready SHALL be 1 in the next cycle; reset in any state aborts the job with no out_valid pulse.

Configuration
REQ-031 With SHA256_SEQ_FEEDFORWARD_EN defined, FIN SHALL set tx_hash word i = st_reg word i + iv_reg word i, for i = 0..7.
REQ-032 Without SHA256_SEQ_FEEDFORWARD_EN, FIN SHALL set tx_hash=st_reg (raw post-round state), and iv_reg may be omitted; latency is unchanged.

Verification
REQ-033 FIPS IV (word0=0x6a09e667 ... word7=0x5be0cd19) with the padded "abc" block (W[0]=0x61626380, W[15]=0x00000018, others 0) -> with the macro, tx_hash word0=0xba7816bf and word7=0xf20015ad; without it, word0=0x506e3058.
REQ-034 Latency check: accept at edge T with out_ready=1 held -> out_valid is high exactly one cycle (after edge T+65); rnd_k_o=0x428a2f98 in the first RUN cycle and 0xc67178f2 in the last.
REQ-035 Backpressure: out_ready=0 for 20 cycles -> out_valid and tx_hash are stable; in_ready=0; in_valid pulses are ignored; the output is released on the first out_ready=1 edge.
REQ-036 Reset mid-run: rst asserted at cnt=30 -> all outputs zero immediately; no out_valid; a new "abc" job afterwards yields the correct digest.
REQ-037 Back-to-back: in_valid and out_ready held high over two jobs -> accepts are 67 cycles apart; both digests are correct, and the second uses its own rx_state.

Source files
------------

// File: rtl/sha256_round_sequencer.sv
// SHA-256 round sequencer: issues 64 rounds to an external combinational round unit.
// Optional build macro SHA256_SEQ_FEEDFORWARD_EN adds the chaining-state feed-forward at FIN.
module sha256_round_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] rx_state,
  input  logic [511:0] rx_block,
  output logic [255:0] rnd_state_o,
  output logic [511:0] rnd_w_o,
  output logic [31:0]  rnd_k_o,
  input  logic [255:0] rnd_state_i,
  input  logic [511:0] rnd_w_i,
  output logic         rnd_active,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] tx_hash
);

  typedef enum logic [1:0] {IDLE, RUN, FIN, OUT} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t        state, state_nxt;
  logic [5:0]    cnt;
  logic [255:0]  st_reg;
  logic [511:0]  w_reg;
  logic [255:0]  hash_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // in_ready is gated by rst so it reads 0 throughout reset, not just after it.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    rnd_active = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        rnd_active = 1'b1;
        if (cnt == 6'd63) state_nxt = FIN;
      end
      FIN: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rnd_state_o = st_reg;
  assign rnd_w_o     = w_reg;
  assign rnd_k_o     = rnd_active ? K_ROM[cnt] : '0;

`ifdef SHA256_SEQ_FEEDFORWARD_EN
  logic [255:0] iv_reg;

  always_comb begin
    hash_nxt = '0;
    for (int unsigned i = 0; i < 8; i++)
      hash_nxt[32*i +: 32] = st_reg[32*i +: 32] + iv_reg[32*i +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           iv_reg <= '0;
    else if (state == IDLE && in_valid) iv_reg <= rx_state;
  end
`else
  assign hash_nxt = st_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      st_reg  <= '0;
      w_reg   <= '0;
      tx_hash <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st_reg <= rx_state;
          w_reg  <= rx_block;
          cnt    <= '0;
        end
        RUN: begin
          st_reg <= rnd_state_i;
          w_reg  <= rnd_w_i;
          cnt    <= cnt + 6'd1;
        end
        FIN:     tx_hash <= hash_nxt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Directed bench for sha256_round_sequencer; supplies the combinational round unit.
module tb_sha256_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] rx_state;
  logic [511:0] rx_block;
  logic [255:0] rnd_state_o;
  logic [511:0] rnd_w_o;
  logic [31:0]  rnd_k_o;
  logic [255:0] rnd_state_i;
  logic [511:0] rnd_w_i;
  logic         rnd_active;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] tx_hash;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sha256_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_state(rx_state), .rx_block(rx_block),
    .rnd_state_o(rnd_state_o), .rnd_w_o(rnd_w_o), .rnd_k_o(rnd_k_o),
    .rnd_state_i(rnd_state_i), .rnd_w_i(rnd_w_i), .rnd_active(rnd_active),
    .out_valid(out_valid), .out_ready(out_ready), .tx_hash(tx_hash)
  );

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 round: returns {next window, next state}.
  function automatic logic [767:0] round_fn(input logic [255:0] s, input logic [511:0] w,
                                            input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wn, s0, s1;
    a = s[31:0];    b = s[63:32];   c = s[95:64];   d = s[127:96];
    e = s[159:128]; f = s[191:160]; g = s[223:192]; h = s[255:224];
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w[31:0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    s0 = rotr(w[63:32], 7) ^ rotr(w[63:32], 18) ^ (w[63:32] >> 3);
    s1 = rotr(w[479:448], 17) ^ rotr(w[479:448], 19) ^ (w[479:448] >> 10);
    wn = s1 + w[319:288] + s0 + w[31:0];
    return {wn, w[511:32], g, f, e, d + t1, c, b, a, t1 + t2};
  endfunction

  function automatic logic [255:0] exp_digest(input logic [255:0] iv, input logic [511:0] blk);
    logic [255:0] s;
    logic [511:0] w;
    logic [767:0] r;
    s = iv;
    w = blk;
    for (int t = 0; t < 64; t++) begin
      r = round_fn(s, w, KT[t]);
      s = r[255:0];
      w = r[767:256];
    end
`ifdef SHA256_SEQ_FEEDFORWARD_EN
    for (int i = 0; i < 8; i++) s[32*i +: 32] = s[32*i +: 32] + iv[32*i +: 32];
`endif
    return s;
  endfunction

  logic [767:0] rr;
  assign rr          = round_fn(rnd_state_o, rnd_w_o, rnd_k_o);
  assign rnd_state_i = rr[255:0];
  assign rnd_w_i     = rr[767:256];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] IV1 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] IV2 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA256_SEQ_FEEDFORWARD_EN
  localparam logic [31:0] ABC_W0 = 32'hba7816bf;
`else
  localparam logic [31:0] ABC_W0 = 32'h506e3058;
`endif

  initial begin
    logic [511:0] abc;
    logic [255:0] exp1, exp2, held;
    int bad, acc_n, out_n;
    int acc_t [4];
    logic [255:0] out_h [4];
    logic acc;

    abc = '0;
    abc[31:0]    = 32'h61626380;
    abc[511:480] = 32'h00000018;
    exp1 = exp_digest(IV1, abc);
    exp2 = exp_digest(IV2, abc);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rx_state = '0; rx_block = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rnd_active", rnd_active, 0);
    chk("rst_rnd_k", rnd_k_o, 0);
    chk("rst_tx_hash", tx_hash, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Latency and "abc" digest with out_ready held high
    rx_state = IV1; rx_block = abc; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("run_active", rnd_active, 1);
    chk("k_first", rnd_k_o, 32'h428a2f98);
    chk("run_in_ready", in_ready, 0);
    repeat (63) tick();
    chk("k_last", rnd_k_o, 32'hc67178f2);
    chk("last_out_valid", out_valid, 0);
    tick();
    chk("fin_out_valid", out_valid, 0);
    chk("fin_k", rnd_k_o, 0);
    chk("fin_active", rnd_active, 0);
    tick();
    chk("lat_out_valid", out_valid, 1);
    chk("abc_word0", tx_hash[31:0], ABC_W0);
    chk("abc_full", tx_hash, exp1);
    tick();
    chk("one_cycle_valid", out_valid, 0);
    chk("back_idle", in_ready, 1);

    // Backpressure with a different chaining state
    rx_state = IV2; rx_block = abc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (65) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_hash", tx_hash, exp2);
    held = tx_hash;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      rx_state = {8{$urandom}};
      tick();
      if (out_valid !== 1'b1 || tx_hash !== held || in_ready !== 1'b0) bad++;
    end
    chk("bp_stable", bad, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    chk("bp_no_accept", rnd_active, 0);

    // Reset mid-run at cnt=30
    rx_state = IV1; rx_block = abc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_active", rnd_active, 0);
    chk("mr_k", rnd_k_o, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_tx_hash", tx_hash, 0);
    chk("mr_state_o", rnd_state_o, 0);
    chk("mr_w_o", rnd_w_o[255:0] | rnd_w_o[511:256], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("mr_no_valid", bad, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (65) tick();
    chk("mr_new_valid", out_valid, 1);
    chk("mr_new_hash", tx_hash, exp1);
    tick();

    // Back-to-back jobs with in_valid and out_ready held high
    rx_state = IV1; rx_block = abc; in_valid = 1'b1; out_ready = 1'b1;
    acc_n = 0; out_n = 0;
    for (int i = 0; i < 134; i++) begin
      acc = in_ready & in_valid;
      tick();
      if (acc && acc_n < 4) begin acc_t[acc_n] = i; acc_n++; end
      if (out_valid && out_n < 4) begin out_h[out_n] = tx_hash; out_n++; end
      if (acc_n >= 1) rx_state = IV2;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_n, 2);
    chk("b2b_outputs", out_n, 2);
    if (acc_n == 2) chk("b2b_spacing", acc_t[1] - acc_t[0], 67);
    if (out_n == 2) begin
      chk("b2b_hash1", out_h[0], exp1);
      chk("b2b_hash2", out_h[1], exp2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
